// File: rtl/ms_pkg.sv
// rtl/ms_pkg.sv - shared constants and FSM state type for the multiplier feeder
package ms_pkg;

  localparam int MS_DW    = 8;
  localparam int MS_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_ARM    = 2'd2,
    ST_WAIT   = 2'd3
  } ms_state_e;

endpackage

// File: rtl/ms_fifo.sv
// rtl/ms_fifo.sv - operand-pair FIFO with registered level and no fall-through
module ms_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_ready,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  // Full and empty come from the registered level, so a pop never frees a slot in the same cycle.
  assign w_push = i_push && (r_level != FULL_LEVEL);
  assign w_pop  = i_pop && (r_level != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_ready = (r_level != FULL_LEVEL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/ms_feed.sv
// rtl/ms_feed.sv - queues operand pairs and launches them one at a time into the multiplier
module ms_feed
  import ms_pkg::*;
#(
  parameter int DW    = MS_DW,
  parameter int DEPTH = MS_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [DW-1:0]              i_multd,
  input  logic [DW-1:0]              i_multr,
  output logic                       o_start,
  output logic [DW-1:0]              o_multd_val,
  output logic [DW-1:0]              o_multr_val,
  input  logic                       i_stop,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level
);

  ms_state_e         r_state;
  ms_state_e         w_next;
  logic              w_pop;
  logic              w_empty;
  logic [2*DW-1:0]   w_rdata;
  logic [DW-1:0]     r_multd;
  logic [DW-1:0]     r_multr;

  ms_fifo #(
    .W     (2 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_pop   (w_pop),
    .i_wdata ({i_multd, i_multr}),
    .o_rdata (w_rdata),
    .o_ready (o_ready),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // ARM waits for i_stop to drop so a completion flag left high by the previous job is not taken as done.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: w_next = ST_ARM;
      ST_ARM:    if (!i_stop) w_next = ST_WAIT;
      ST_WAIT:   if (i_stop) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_multd <= '0;
      r_multr <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        {r_multd, r_multr} <= w_rdata;
      end
    end
  end

  assign o_start     = (r_state == ST_LAUNCH);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_multd_val = r_multd;
  assign o_multr_val = r_multr;

endmodule
